parity_stream: RTL

- Parametrised, streaming successor to the team's 8-bit combinational parity generator.
- Accepts DATA_W-bit words on a valid/ready interface and computes per-word parity, selectable even/odd.
- Accumulates a running frame parity across multi-word frames delimited by in_last.
- Operates as generator, or as checker against a received parity bit.
- Sits between a byte/word source (UART/SPI datapath) and its consumer; registered, single-stage pipeline.

---
 rtl/parity_stream_pkg.sv | 18 +
 rtl/parity_stream_if.sv | 39 +++
 rtl/parity_stream_reduce.sv | 16 +
 rtl/parity_stream.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/parity_stream_pkg.sv
// Shared types and defaults for the streaming parity block.
// Contents: parity mode encoding, frame FSM state type, default widths.
package parity_pkg;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_mode_e;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } frame_state_e;

  localparam int unsigned PAR_DATA_W_DEF = 8;
  localparam int unsigned PAR_CNT_W_DEF  = 16;

endpackage

// File: rtl/parity_stream_if.sv
// Handshake/data bundle for parity_stream.
// Input side : odd_sel, chk_mode, in_valid/in_ready, in_data, in_par, in_last.
// Output side: out_valid/out_ready, out_data, out_par, out_err, out_last,
//              out_frame_par.
// Modports: master = word source and result consumer, slave = parity_stream.
interface parity_stream_if
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = PAR_DATA_W_DEF
) ();

  logic              odd_sel;
  logic              chk_mode;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_par;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_par;
  logic              out_err;
  logic              out_last;
  logic              out_frame_par;

  modport master (
    output odd_sel, chk_mode, in_valid, in_data, in_par, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_par, out_err, out_last,
           out_frame_par
  );

  modport slave (
    input  odd_sel, chk_mode, in_valid, in_data, in_par, in_last, out_ready,
    output in_ready, out_valid, out_data, out_par, out_err, out_last,
           out_frame_par
  );

endinterface

// File: rtl/parity_stream_reduce.sv
// parity_reduce: combinational XOR-reduce of a DATA_W-bit word, optionally
// inverted by odd_sel_i (odd parity).
// Ports: data_i (DATA_W) word, odd_sel_i inversion, par_o parity bit.
module parity_reduce
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = PAR_DATA_W_DEF
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              odd_sel_i,
  output logic              par_o
);

  assign par_o = (^data_i) ^ odd_sel_i;

endmodule

// File: rtl/parity_stream.sv
// parity_stream: streaming per-word and per-frame parity generator/checker
// with a single registered output stage and valid/ready flow control.
// Ports:
//   clk, rst  - rising-edge clock, synchronous active-high reset
//   bus       - parity_stream_if.slave (input word handshake + result handshake)
//   err_cnt   - saturating count of handshaken out_err results; exists only
//               when PARITY_ERR_CNT_EN is defined
// Parameters: DATA_W word width (1..64), FRAME_EN frame parity enable,
//   CNT_W error counter width.
// Build option: `define PARITY_ERR_CNT_EN adds the err_cnt port and counter.
module parity_stream
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W   = PAR_DATA_W_DEF,
  parameter bit          FRAME_EN = 1'b1,
  parameter int unsigned CNT_W    = PAR_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  parity_stream_if.slave       bus
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]     err_cnt
`endif
);

  if (DATA_W < 1 || DATA_W > 64) begin : g_bad_data_w
    $error("parity_stream: DATA_W must be in 1..64");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("parity_stream: CNT_W must be at least 1");
  end

  par_mode_e         mode;
  logic              odd;
  logic              accept;
  logic              word_par;
  logic              data_xor;

  frame_state_e      state_q, state_d;
  logic              acc_q, acc_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_par_q, out_par_d;
  logic              out_err_q, out_err_d;
  logic              out_last_q, out_last_d;
  logic              out_fpar_q, out_fpar_d;

  assign mode = par_mode_e'(bus.odd_sel);
  assign odd  = (mode == PAR_ODD);

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  parity_reduce #(.DATA_W(DATA_W)) u_word_par (
    .data_i    (bus.in_data),
    .odd_sel_i (odd),
    .par_o     (word_par)
  );

  parity_reduce #(.DATA_W(DATA_W)) u_frame_xor (
    .data_i    (bus.in_data),
    .odd_sel_i (1'b0),
    .par_o     (data_xor)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_par_d   = out_par_q;
    out_err_d   = out_err_q;
    out_last_d  = out_last_q;
    out_fpar_d  = out_fpar_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data;
      out_par_d   = word_par;
      out_err_d   = bus.chk_mode && (word_par != bus.in_par);
      out_last_d  = bus.in_last;
      out_fpar_d  = FRAME_EN ? (acc_q ^ data_xor ^ odd) : 1'b0;

      if (bus.in_last) begin
        state_d = IDLE;
        acc_d   = 1'b0;
      end else begin
        state_d = IN_FRAME;
        // IDLE guarantees acc_q == 0, so the first word seeds the accumulator.
        acc_d   = (state_q == IDLE) ? data_xor : (acc_q ^ data_xor);
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_par_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_fpar_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_par_q   <= out_par_d;
      out_err_q   <= out_err_d;
      out_last_q  <= out_last_d;
      out_fpar_q  <= out_fpar_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_par       = out_par_q;
  assign bus.out_err       = out_err_q;
  assign bus.out_last      = out_last_q;
  assign bus.out_frame_par = out_fpar_q;

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Counts on result completion, not on acceptance, so stalled results
  // are counted exactly once.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (out_valid_q && bus.out_ready && out_err_q && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
